// File: rtl/adapter_to_bus_if.sv
// Handshake bundle between the message source, the adapter and the 32-bit bus.
// The slave view is the adapter; the master view is whatever drives and sinks it.
interface adapter_to_bus_if;
   logic         in_enq_ena;
   logic [127:0] in_enq_v;
   logic [15:0]  in_enq_length;
   logic         in_enq_rdy;
   logic         out_enq_ena;
   logic [31:0]  out_enq_v;
   logic         out_enq_last;
   logic         out_enq_rdy;

   modport slave (
      input  in_enq_ena,
      input  in_enq_v,
      input  in_enq_length,
      output in_enq_rdy,
      output out_enq_ena,
      output out_enq_v,
      output out_enq_last,
      input  out_enq_rdy
   );

   modport master (
      output in_enq_ena,
      output in_enq_v,
      output in_enq_length,
      input  in_enq_rdy,
      input  out_enq_ena,
      input  out_enq_v,
      input  out_enq_last,
      output out_enq_rdy
   );
endinterface

// File: rtl/adapter_to_bus.sv
// Serializes a 128-bit message into 1..4 32-bit beats, most significant word first.
// Optional macro ADAPTER_TO_BUS_BACK_TO_BACK_EN accepts the next message on the last beat.
//
// state | meaning
// IDLE  | no message held, ready for a new one
// SEND  | message held, beat idx on the bus
module adapter_to_bus (
   input  logic             CLK,
   input  logic             RST,
   adapter_to_bus_if.slave  bus
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t        state;
   logic [1:0]    idx;
   logic [127:0]  msg_buf;
   logic [31:0]   out_v_q;
   logic          out_last_q;
   logic          out_ena_q;
   logic          in_rdy_q;
   logic [1:0]    new_idx;

   // Index of the highest word present; 0 or oversize lengths mean a full message.
   function automatic logic [1:0] last_idx(input logic [15:0] len);
      if (len == 16'd0 || len > 16'd16) return 2'd3;
      else if (len <= 16'd4)            return 2'd0;
      else if (len <= 16'd8)            return 2'd1;
      else if (len <= 16'd12)           return 2'd2;
      else                              return 2'd3;
   endfunction

   function automatic logic [31:0] word_of(input logic [127:0] m, input logic [1:0] k);
      case (k)
         2'd0:    return m[31:0];
         2'd1:    return m[63:32];
         2'd2:    return m[95:64];
         default: return m[127:96];
      endcase
   endfunction

   assign new_idx = last_idx(bus.in_enq_length);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         idx        <= 2'd0;
         msg_buf    <= '0;
         out_v_q    <= '0;
         out_last_q <= 1'b0;
         out_ena_q  <= 1'b0;
         in_rdy_q   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_enq_ena) begin
                  msg_buf    <= bus.in_enq_v;
                  idx        <= new_idx;
                  out_v_q    <= word_of(bus.in_enq_v, new_idx);
                  out_last_q <= (new_idx == 2'd0);
                  out_ena_q  <= 1'b1;
                  in_rdy_q   <= 1'b0;
                  state      <= SEND;
               end
            end
            SEND: begin
               if (bus.out_enq_rdy) begin
                  if (idx != 2'd0) begin
                     idx        <= idx - 2'd1;
                     out_v_q    <= word_of(msg_buf, idx - 2'd1);
                     out_last_q <= (idx == 2'd1);
                  end else begin
`ifdef ADAPTER_TO_BUS_BACK_TO_BACK_EN
                     if (bus.in_enq_ena) begin
                        msg_buf    <= bus.in_enq_v;
                        idx        <= new_idx;
                        out_v_q    <= word_of(bus.in_enq_v, new_idx);
                        out_last_q <= (new_idx == 2'd0);
                        out_ena_q  <= 1'b1;
                        in_rdy_q   <= 1'b0;
                        state      <= SEND;
                     end else begin
                        out_v_q    <= '0;
                        out_last_q <= 1'b0;
                        out_ena_q  <= 1'b0;
                        in_rdy_q   <= 1'b1;
                        state      <= IDLE;
                     end
`else
                     out_v_q    <= '0;
                     out_last_q <= 1'b0;
                     out_ena_q  <= 1'b0;
                     in_rdy_q   <= 1'b1;
                     state      <= IDLE;
`endif
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ADAPTER_TO_BUS_BACK_TO_BACK_EN
   // Last beat leaving this cycle frees the buffer, so a new message may load in its place.
   assign bus.in_enq_rdy = in_rdy_q |
                           ((state == SEND) && (idx == 2'd0) && bus.out_enq_rdy);
`else
   assign bus.in_enq_rdy = in_rdy_q;
`endif
   assign bus.out_enq_ena  = out_ena_q;
   assign bus.out_enq_v    = out_v_q;
   assign bus.out_enq_last = out_last_q;

endmodule

// File: tb/tb_adapter_to_bus.sv
// Directed bench for adapter_to_bus: table of message lengths plus stall,
// back-to-back and mid-message reset sequences.
module tb_adapter_to_bus;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   adapter_to_bus_if bus();

   adapter_to_bus dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   localparam logic [127:0] VA = 128'h44444444_33333333_22222222_11111111;
   localparam logic [127:0] VB = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

   typedef struct {
      logic [15:0] len;
      int          n;
   } vec_t;

   vec_t        vecs [9];
   logic [31:0] wa   [4];
   int          pat  [7];

   task automatic tick;
      @(posedge CLK);
      #2;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic enqueue(input logic [15:0] len, input logic [127:0] v);
      int w;
      w = 0;
      while (bus.in_enq_rdy !== 1'b1 && w < 20) begin
         tick();
         w++;
      end
      chk("enq_wait_rdy", bus.in_enq_rdy, 1'b1);
      bus.in_enq_ena    = 1'b1;
      bus.in_enq_v      = v;
      bus.in_enq_length = len;
      tick();
      bus.in_enq_ena    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int xfers;
      int r;

      wa[0] = 32'h11111111; wa[1] = 32'h22222222;
      wa[2] = 32'h33333333; wa[3] = 32'h44444444;
      vecs[0] = '{16'd16,  4};
      vecs[1] = '{16'd5,   2};
      vecs[2] = '{16'd0,   4};
      vecs[3] = '{16'd100, 4};
      vecs[4] = '{16'd4,   1};
      vecs[5] = '{16'd8,   2};
      vecs[6] = '{16'd13,  4};
      vecs[7] = '{16'd9,   3};
      vecs[8] = '{16'd1,   1};
      pat = '{1, 0, 0, 1, 1, 0, 1};

      RST = 1'b1;
      bus.in_enq_ena    = 1'b0;
      bus.in_enq_v      = '0;
      bus.in_enq_length = '0;
      bus.out_enq_rdy   = 1'b1;
      tick();
      tick();
      chk("rst_in_rdy",   bus.in_enq_rdy,   1'b1);
      chk("rst_out_ena",  bus.out_enq_ena,  1'b0);
      chk("rst_out_v",    bus.out_enq_v,    32'h0);
      chk("rst_out_last", bus.out_enq_last, 1'b0);
      RST = 1'b0;
      tick();

      // Length table with the bus always ready: beats N-1..0 on consecutive cycles.
      for (int i = 0; i < 9; i++) begin
         enqueue(vecs[i].len, VA);
         for (int b = 0; b < vecs[i].n; b++) begin
            chk($sformatf("tbl%0d_ena_b%0d", i, b),  bus.out_enq_ena,  1'b1);
            chk($sformatf("tbl%0d_v_b%0d", i, b),    bus.out_enq_v,    wa[vecs[i].n - 1 - b]);
            chk($sformatf("tbl%0d_last_b%0d", i, b), bus.out_enq_last, (b == vecs[i].n - 1));
            tick();
         end
         chk($sformatf("tbl%0d_done_ena", i), bus.out_enq_ena, 1'b0);
         chk($sformatf("tbl%0d_done_v", i),   bus.out_enq_v,   32'h0);
         chk($sformatf("tbl%0d_done_rdy", i), bus.in_enq_rdy,  1'b1);
      end

      // Stalls: data and last hold while the bus is not ready.
      enqueue(16'd16, VA);
      k = 3;
      xfers = 0;
      for (int c = 0; c < 12 && xfers < 4; c++) begin
         r = (c < 7) ? pat[c] : 1;
         bus.out_enq_rdy = (r != 0);
         chk($sformatf("stall_ena_c%0d", c),  bus.out_enq_ena,  1'b1);
         chk($sformatf("stall_v_c%0d", c),    bus.out_enq_v,    wa[k]);
         chk($sformatf("stall_last_c%0d", c), bus.out_enq_last, (k == 0));
         tick();
         if (r != 0) begin
            xfers++;
            k--;
         end
      end
      bus.out_enq_rdy = 1'b1;
      chk("stall_xfers",    xfers,           4);
      chk("stall_done_ena", bus.out_enq_ena, 1'b0);
      tick();

      // Two messages queued; an enqueue on a non-last beat must be ignored.
      enqueue(16'd8, VA);
      bus.in_enq_ena    = 1'b1;
      bus.in_enq_v      = VB;
      bus.in_enq_length = 16'd4;
      #1;
      chk("b2b_busy_rdy", bus.in_enq_rdy,   1'b0);
      chk("b2b_a_v1",     bus.out_enq_v,    wa[1]);
      chk("b2b_a_last1",  bus.out_enq_last, 1'b0);
      tick();
      chk("b2b_a_v0",    bus.out_enq_v,    wa[0]);
      chk("b2b_a_last0", bus.out_enq_last, 1'b1);
`ifdef ADAPTER_TO_BUS_BACK_TO_BACK_EN
      chk("b2b_last_rdy", bus.in_enq_rdy, 1'b1);
      tick();
      bus.in_enq_ena = 1'b0;
`else
      chk("b2b_last_rdy", bus.in_enq_rdy, 1'b0);
      tick();
      chk("b2b_gap_ena", bus.out_enq_ena, 1'b0);
      chk("b2b_gap_rdy", bus.in_enq_rdy,  1'b1);
      tick();
      bus.in_enq_ena = 1'b0;
`endif
      chk("b2b_b_ena",  bus.out_enq_ena,  1'b1);
      chk("b2b_b_v",    bus.out_enq_v,    32'hAAAAAAAA);
      chk("b2b_b_last", bus.out_enq_last, 1'b1);
      tick();
      chk("b2b_done_ena", bus.out_enq_ena, 1'b0);
      tick();

      // Reset after two beats of four, with a competing enqueue.
      enqueue(16'd16, VA);
      tick();
      tick();
      chk("rstmid_pre_v", bus.out_enq_v, wa[1]);
      RST = 1'b1;
      bus.in_enq_ena    = 1'b1;
      bus.in_enq_v      = VB;
      bus.in_enq_length = 16'd4;
      tick();
      chk("rstmid_ena",  bus.out_enq_ena,  1'b0);
      chk("rstmid_rdy",  bus.in_enq_rdy,   1'b1);
      chk("rstmid_v",    bus.out_enq_v,    32'h0);
      chk("rstmid_last", bus.out_enq_last, 1'b0);
      RST = 1'b0;
      bus.in_enq_ena = 1'b0;
      tick();
      chk("rstmid_after_ena", bus.out_enq_ena, 1'b0);
      enqueue(16'd4, VA);
      chk("rstmid_new_ena",  bus.out_enq_ena,  1'b1);
      chk("rstmid_new_v",    bus.out_enq_v,    wa[0]);
      chk("rstmid_new_last", bus.out_enq_last, 1'b1);
      tick();
      chk("rstmid_new_done", bus.out_enq_ena, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
